// File: rtl/fe_fifo_writer.sv
// fe_fifo_writer: packs sniffed bytes and status events into 18-bit sniff-FIFO
// words {cmd[1:0], delta[7:0], payload[7:0]}. It inserts START/OVERFLOW stream
// markers and TIME ticks, and drops and counts events under FIFO back-pressure.
//
// Ports:
//   cwusb_clk      clock
//   reset_i        asynchronous active-high reset
//   I_arm          capture enable (level); a rising edge starts a new capture
//   I_data_valid   one-cycle strobe qualifying I_data
//   I_data         sniffed byte
//   I_stat_valid   one-cycle strobe qualifying I_stat
//   I_stat         status code
//   I_fifo_afull   FIFO has fewer than 2 free entries
//   O_fifo_wr      FIFO write enable (registered)
//   O_fifo_data    FIFO write word (registered)
//   O_overflow     sticky drop flag, cleared on an arm rising edge
//   O_drop_count   saturating dropped-event count, cleared on an arm rising edge
module fe_fifo_writer #(
  parameter int unsigned pTIME_WIDTH = 8,
  parameter int unsigned pDROP_WIDTH = 16
) (
  input  logic                   cwusb_clk,
  input  logic                   reset_i,
  input  logic                   I_arm,
  input  logic                   I_data_valid,
  input  logic [7:0]             I_data,
  input  logic                   I_stat_valid,
  input  logic [7:0]             I_stat,
  input  logic                   I_fifo_afull,
  output logic                   O_fifo_wr,
  output logic [17:0]            O_fifo_data,
  output logic                   O_overflow,
  output logic [pDROP_WIDTH-1:0] O_drop_count
);

  localparam int unsigned TW   = pTIME_WIDTH;
  localparam int unsigned DW   = pDROP_WIDTH;
  localparam int unsigned DWP1 = pDROP_WIDTH + 1;

  localparam logic [1:0] CMD_DATA = 2'd0;
  localparam logic [1:0] CMD_TIME = 2'd1;
  localparam logic [1:0] CMD_STAT = 2'd2;
  localparam logic [1:0] CMD_STRM = 2'd3;

  localparam logic [7:0] STRM_START = 8'h02;
  localparam logic [7:0] STRM_OVFL  = 8'h03;

  localparam logic [TW-1:0] TIME_MAX = '1;
  localparam logic [DW-1:0] DROP_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_CAPTURE,
    ST_OVFL
  } state_t;

  state_t         state_q, state_d;
  logic           arm_q, arm_d;
  logic           wr_q, wr_d;
  logic [17:0]    data_q, data_d;
  logic           ovf_q, ovf_d;
  logic [DW-1:0]  drop_q, drop_d;
  logic [TW-1:0]  time_q, time_d;
  logic           hold_vld_q, hold_vld_d;
  logic [7:0]     hold_q, hold_d;

  logic [1:0]     drop_inc;
  logic [DW:0]    drop_sum;
  logic [TW-1:0]  time_inc;
  logic           tick;
  logic           stat_evt;
  logic [7:0]     stat_payload;
  logic           need_wr;

  // Next-state, write-word and bookkeeping decisions for the current cycle.
  always_comb begin
    state_d    = state_q;
    arm_d      = I_arm;
    wr_d       = 1'b0;
    data_d     = data_q;
    ovf_d      = ovf_q;
    drop_d     = drop_q;
    time_d     = time_q;
    hold_vld_d = hold_vld_q;
    hold_d     = hold_q;
    drop_inc   = 2'd0;
    drop_sum   = '0;

    tick         = (time_q == TIME_MAX);
    // Saturating increment: the count never wraps while a write is blocked.
    time_inc     = tick ? time_q : time_q + TW'(1);
    // A held STAT goes out ahead of a newly arriving one to keep the order.
    stat_evt     = I_stat_valid | hold_vld_q;
    stat_payload = hold_vld_q ? hold_q : I_stat;
    need_wr      = I_data_valid | stat_evt | tick;

    if (!I_arm) begin
      state_d    = ST_IDLE;
      hold_vld_d = 1'b0;
      time_d     = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!arm_q) begin
            state_d = ST_START;
            ovf_d   = 1'b0;
            drop_d  = '0;
            time_d  = '0;
          end
        end

        ST_START: begin
          if (!I_fifo_afull) begin
            wr_d    = 1'b1;
            data_d  = {CMD_STRM, 8'h00, STRM_START};
            time_d  = '0;
            state_d = ST_CAPTURE;
          end else begin
            time_d = time_inc;
          end
        end

        ST_CAPTURE: begin
          if (need_wr && I_fifo_afull) begin
            // Triggering events and any held STAT are lost on entry to OVFL.
            state_d    = ST_OVFL;
            drop_inc   = 2'(I_data_valid) + 2'(I_stat_valid) + 2'(hold_vld_q);
            hold_vld_d = 1'b0;
            time_d     = time_inc;
          end else if (I_data_valid) begin
            wr_d   = 1'b1;
            data_d = {CMD_DATA, 8'(time_q), I_data};
            time_d = '0;
            if (I_stat_valid) begin
              if (hold_vld_q) begin
                drop_inc = 2'd1;
              end
              hold_vld_d = 1'b1;
              hold_d     = I_stat;
            end
          end else if (stat_evt) begin
            wr_d       = 1'b1;
            data_d     = {CMD_STAT, 8'(time_q), stat_payload};
            time_d     = '0;
            // Only a held STAT plus a new strobe leaves something in the hold.
            hold_vld_d = hold_vld_q & I_stat_valid;
            if (I_stat_valid) begin
              hold_d = I_stat;
            end
          end else if (tick) begin
            wr_d   = 1'b1;
            data_d = {CMD_TIME, 8'h00, 8'hFF};
            time_d = '0;
          end else begin
            time_d = time_inc;
          end
        end

        ST_OVFL: begin
          drop_inc = 2'(I_data_valid) + 2'(I_stat_valid);
          if (!I_fifo_afull) begin
            wr_d    = 1'b1;
            data_d  = {CMD_STRM, 8'h00, STRM_OVFL};
            time_d  = '0;
            state_d = ST_CAPTURE;
          end else begin
            time_d = time_inc;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end

    if (drop_inc != 2'd0) begin
      ovf_d    = 1'b1;
      drop_sum = {1'b0, drop_q} + DWP1'(drop_inc);
      drop_d   = drop_sum[DW] ? DROP_MAX : drop_sum[DW-1:0];
    end
  end

  // State and output registers.
  always_ff @(posedge cwusb_clk or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      arm_q      <= 1'b0;
      wr_q       <= 1'b0;
      data_q     <= '0;
      ovf_q      <= 1'b0;
      drop_q     <= '0;
      time_q     <= '0;
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      arm_q      <= arm_d;
      wr_q       <= wr_d;
      data_q     <= data_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
      time_q     <= time_d;
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
    end
  end

  assign O_fifo_wr    = wr_q;
  assign O_fifo_data  = data_q;
  assign O_overflow   = ovf_q;
  assign O_drop_count = drop_q;

endmodule

// File: tb/tb_fe_fifo_writer.sv
// Scoreboard bench for fe_fifo_writer: stimulus pushes expected FIFO words,
// a negedge monitor pops and compares on every O_fifo_wr.
module tb_fe_fifo_writer;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        I_arm;
  logic        I_data_valid;
  logic [7:0]  I_data;
  logic        I_stat_valid;
  logic [7:0]  I_stat;
  logic        I_fifo_afull;
  logic        O_fifo_wr;
  logic [17:0] O_fifo_data;
  logic        O_overflow;
  logic [15:0] O_drop_count;

  logic [17:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  fe_fifo_writer #(.pTIME_WIDTH(8), .pDROP_WIDTH(16)) dut (
    .cwusb_clk    (clk),
    .reset_i      (reset_i),
    .I_arm        (I_arm),
    .I_data_valid (I_data_valid),
    .I_data       (I_data),
    .I_stat_valid (I_stat_valid),
    .I_stat       (I_stat),
    .I_fifo_afull (I_fifo_afull),
    .O_fifo_wr    (O_fifo_wr),
    .O_fifo_data  (O_fifo_data),
    .O_overflow   (O_overflow),
    .O_drop_count (O_drop_count)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; returns 1 time unit after the last edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    reset_i      = 1'b1;
    I_arm        = 1'b0;
    I_data_valid = 1'b0;
    I_data       = 8'h00;
    I_stat_valid = 1'b0;
    I_stat       = 8'h00;
    I_fifo_afull = 1'b0;

    fork
      begin : monitor
        forever begin
          @(negedge clk);
          if (!reset_i && O_fifo_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_write: got %h expected no write", O_fifo_data);
            end else begin
              chk("fifo_word", 32'(O_fifo_data), 32'(exp_q.pop_front()));
            end
          end
        end
      end

      begin : stimulus
        // Reset values.
        cyc(3);
        chk("rst_wr", 32'(O_fifo_wr), 32'd0);
        chk("rst_data", 32'(O_fifo_data), 32'd0);
        chk("rst_ovf", 32'(O_overflow), 32'd0);
        chk("rst_drop", 32'(O_drop_count), 32'd0);
        reset_i = 1'b0;
        cyc(2);

        // Arm: rise at E1, START written at E2. DATA sampled at E8 sees 5 idle
        // increments after the START write clears time_cnt.
        I_arm = 1'b1;
        exp_q.push_back(18'h30002);
        cyc(7);
        exp_q.push_back(18'h005A5);
        I_data_valid = 1'b1; I_data = 8'hA5;
        cyc(1);
        I_data_valid = 1'b0;

        // Quiet for 256 edges -> TIME tick, then count restarts from 0.
        exp_q.push_back(18'h100FF);
        exp_q.push_back(18'h0093C);
        cyc(265);
        I_data_valid = 1'b1; I_data = 8'h3C;
        cyc(1);
        I_data_valid = 1'b0;

        // DATA and STAT together: DATA first, STAT next cycle.
        exp_q.push_back(18'h00011);
        exp_q.push_back(18'h20022);
        I_data_valid = 1'b1; I_data = 8'h11;
        I_stat_valid = 1'b1; I_stat = 8'h22;
        cyc(1);
        I_data_valid = 1'b0; I_stat_valid = 1'b0;
        cyc(1);

        // Back-to-back STATs during a DATA burst: the first is overwritten.
        exp_q.push_back(18'h00040);
        exp_q.push_back(18'h00041);
        exp_q.push_back(18'h00042);
        exp_q.push_back(18'h20052);
        I_data_valid = 1'b1; I_data = 8'h40; I_stat_valid = 1'b1; I_stat = 8'h51;
        cyc(1);
        I_data = 8'h41; I_stat = 8'h52;
        cyc(1);
        I_data = 8'h42; I_stat_valid = 1'b0;
        cyc(1);
        I_data_valid = 1'b0;
        cyc(1);
        chk("stat_ovw_drop", 32'(O_drop_count), 32'd1);
        chk("stat_ovw_ovf", 32'(O_overflow), 32'd1);

        // Re-arm clears the drop state on the rising edge itself.
        I_arm = 1'b0;
        cyc(2);
        I_arm = 1'b1;
        cyc(1);
        chk("rearm_drop", 32'(O_drop_count), 32'd0);
        chk("rearm_ovf", 32'(O_overflow), 32'd0);
        exp_q.push_back(18'h30002);
        cyc(1);

        // Back-pressure: three bytes dropped, then OVERFLOW marker.
        I_fifo_afull = 1'b1;
        cyc(2);
        I_data_valid = 1'b1; I_data = 8'h90;
        cyc(1);
        I_data = 8'h91;
        cyc(1);
        I_data = 8'h92;
        cyc(1);
        I_data_valid = 1'b0;
        cyc(2);
        chk("afull_drop", 32'(O_drop_count), 32'd3);
        chk("afull_ovf", 32'(O_overflow), 32'd1);
        exp_q.push_back(18'h30003);
        I_fifo_afull = 1'b0;
        cyc(1);
        exp_q.push_back(18'h00077);
        I_data_valid = 1'b1; I_data = 8'h77;
        cyc(1);
        I_data_valid = 1'b0;

        // Disarm mid-burst: nothing after the first byte is written.
        exp_q.push_back(18'h00080);
        I_data_valid = 1'b1; I_data = 8'h80;
        cyc(1);
        I_data = 8'h81; I_arm = 1'b0;
        cyc(1);
        I_data = 8'h82;
        cyc(1);
        I_data_valid = 1'b0;
        cyc(3);
        chk("idle_drop", 32'(O_drop_count), 32'd3);
        chk("idle_wr", 32'(O_fifo_wr), 32'd0);

        // Reset lands while the START write is on the outputs.
        I_arm = 1'b1;
        cyc(2);
        chk("start_inflight", 32'(O_fifo_wr), 32'd1);
        #1;
        reset_i = 1'b1;
        #1;
        chk("async_wr", 32'(O_fifo_wr), 32'd0);
        chk("async_data", 32'(O_fifo_data), 32'd0);
        chk("async_ovf", 32'(O_overflow), 32'd0);
        chk("async_drop", 32'(O_drop_count), 32'd0);
        cyc(2);
        I_arm   = 1'b0;
        reset_i = 1'b0;
        cyc(4);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
      end
    join_any
    disable fork;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
